// File: rtl/cr_cceip_sup_df_mux_n.sv
// cr_cceip_sup_df_mux_n
// N-input AXI4-Stream data-flow mux for the CCEIP support path. The selected
// input only changes at packet boundaries. Output goes through a 2-entry skid
// FIFO. Also provides a saturating packet counter and idle/pending status.
module cr_cceip_sup_df_mux_n #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 64,
   parameter int SEL_W  = $clog2(NUM_IN) + 1,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           cfg_sel,
   input  logic [NUM_IN-1:0]          in_tvalid,
   input  logic [NUM_IN*DATA_W-1:0]   in_tdata,
   input  logic [NUM_IN-1:0]          in_tlast,
   output logic [NUM_IN-1:0]          in_tready,
   output logic                       out_tvalid,
   output logic [DATA_W-1:0]          out_tdata,
   output logic                       out_tlast,
   input  logic                       out_tready,
   output logic [SEL_W-1:0]           cur_sel,
   output logic                       sel_pend,
   output logic [CNT_W-1:0]           pkt_cnt,
   input  logic                       cnt_clr,
   output logic                       mux_idle
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
   logic [NUM_IN-1:0]   in_tready_q, in_tready_d;
   logic [NUM_IN-1:0]   hit_s;
   logic [DATA_W-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic                head_last_q, head_last_d, tail_last_q, tail_last_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic                sel_valid_s, sel_last_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic                acc_s, pop_s;

   // Decode the select in force and steer the matching input lane.
   always_comb begin
      hit_s       = '0;
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         hit_s[i]    = (cur_sel_q == SEL_W'(i));
         sel_valid_s = sel_valid_s | (hit_s[i] & in_tvalid[i]);
         sel_last_s  = sel_last_s  | (hit_s[i] & in_tlast[i]);
         sel_data_s  = sel_data_s  | ({DATA_W{hit_s[i]}} & in_tdata[i*DATA_W +: DATA_W]);
      end
   end

   assign acc_s = |(in_tvalid & in_tready_q & hit_s);
   assign pop_s = (cnt_q != 2'd0) & out_tready;

   // Skid FIFO next state: head entry drives the output, tail holds the overflow beat.
   always_comb begin
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      cnt_d       = cnt_q;
      case ({acc_s, pop_s})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_data_d = sel_data_s;
               head_last_d = sel_last_s;
            end else begin
               tail_data_d = sel_data_s;
               tail_last_d = sel_last_s;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            cnt_d       = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_data_d = sel_data_s;
               head_last_d = sel_last_s;
            end else begin
               head_data_d = tail_data_q;
               head_last_d = tail_last_q;
               tail_data_d = sel_data_s;
               tail_last_d = sel_last_s;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // FSM next state: enter PKT on a non-final beat, leave on the tlast beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (acc_s & ~sel_last_s) begin
               state_d = ST_PKT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PKT: begin
            if (acc_s & sel_last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_PKT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Select follows cfg_sel only while no packet is open after this cycle's beat.
   always_comb begin
      cur_sel_d   = cur_sel_q;
      in_tready_d = '0;
      if (state_d == ST_IDLE) begin
         cur_sel_d = cfg_sel;
      end else begin
         cur_sel_d = cur_sel_q;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         in_tready_d[i] = (cur_sel_d == SEL_W'(i)) & (cnt_d != 2'd2);
      end
   end

   // Packet counter: clear wins over increment, increment saturates.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (cnt_clr) begin
         pkt_cnt_d = '0;
      end else if (acc_s & sel_last_s & (pkt_cnt_q != {CNT_W{1'b1}})) begin
         pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, select and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_sel_q   <= {SEL_W{1'b1}};
         in_tready_q <= '0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         cnt_q       <= 2'd0;
         pkt_cnt_q   <= '0;
      end else begin
         cur_sel_q   <= cur_sel_d;
         in_tready_q <= in_tready_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         cnt_q       <= cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   // FSM outputs: pending switch and idle status.
   always_comb begin
      sel_pend = (state_q == ST_PKT) & (cfg_sel != cur_sel_q);
      mux_idle = (state_q == ST_IDLE) & (cnt_q == 2'd0) & ~sel_valid_s;
   end

   assign in_tready  = in_tready_q;
   assign out_tvalid = (cnt_q != 2'd0);
   assign out_tdata  = head_data_q;
   assign out_tlast  = head_last_q;
   assign cur_sel    = cur_sel_q;
   assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_cr_cceip_sup_df_mux_n.sv
// Directed bench for cr_cceip_sup_df_mux_n (4 inputs, 16-bit data, 4-bit counter).
module tb_cr_cceip_sup_df_mux_n;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 16;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 4;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [SEL_W-1:0]         cfg_sel;
   logic [NUM_IN-1:0]        in_tvalid;
   logic [NUM_IN*DATA_W-1:0] in_tdata;
   logic [NUM_IN-1:0]        in_tlast;
   logic [NUM_IN-1:0]        in_tready;
   logic                     out_tvalid;
   logic [DATA_W-1:0]        out_tdata;
   logic                     out_tlast;
   logic                     out_tready;
   logic [SEL_W-1:0]         cur_sel;
   logic                     sel_pend;
   logic [CNT_W-1:0]         pkt_cnt;
   logic                     cnt_clr;
   logic                     mux_idle;

   int total = 0;
   int bad   = 0;

   cr_cceip_sup_df_mux_n #(
      .NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_sel(cfg_sel),
      .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tready(out_tready),
      .cur_sel(cur_sel), .sel_pend(sel_pend), .pkt_cnt(pkt_cnt), .cnt_clr(cnt_clr), .mux_idle(mux_idle)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int lane, input logic v, input logic [15:0] d, input logic l);
      in_tvalid[lane]            = v;
      in_tdata[lane*16 +: 16]    = d;
      in_tlast[lane]             = l;
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_sel    = 3'd2;
      in_tvalid  = '0;
      in_tdata   = '0;
      in_tlast   = '0;
      out_tready = 1'b1;
      cnt_clr    = 1'b0;
      tick();
      tick();
      // reset state
      chk("rst_out_tvalid", out_tvalid, 1'b0);
      chk("rst_out_tdata",  out_tdata,  16'h0000);
      chk("rst_out_tlast",  out_tlast,  1'b0);
      chk("rst_in_tready",  in_tready,  4'b0000);
      chk("rst_cur_sel",    cur_sel,    3'b111);
      chk("rst_sel_pend",   sel_pend,   1'b0);
      chk("rst_pkt_cnt",    pkt_cnt,    4'd0);
      chk("rst_mux_idle",   mux_idle,   1'b1);

      // 1: three-beat packet on in2
      rst_n = 1'b1;
      tick();
      chk("t1_cur_sel",   cur_sel,    3'd2);
      chk("t1_tready",    in_tready,  4'b0100);
      chk("t1_no_out",    out_tvalid, 1'b0);
      drive(2, 1'b1, 16'hA001, 1'b0);
      tick();
      chk("t1_b1_valid",  out_tvalid, 1'b1);
      chk("t1_b1_data",   out_tdata,  16'hA001);
      chk("t1_b1_last",   out_tlast,  1'b0);
      drive(2, 1'b1, 16'hA002, 1'b0);
      tick();
      chk("t1_b2_data",   out_tdata,  16'hA002);
      drive(2, 1'b1, 16'hA003, 1'b1);
      tick();
      chk("t1_b3_data",   out_tdata,  16'hA003);
      chk("t1_b3_last",   out_tlast,  1'b1);
      chk("t1_pkt_cnt",   pkt_cnt,    4'd1);
      drive(2, 1'b0, 16'h0000, 1'b0);
      tick();
      chk("t1_drained",   out_tvalid, 1'b0);
      chk("t1_idle",      mux_idle,   1'b1);

      // 2: select change mid-packet, in0 waiting with a single-beat packet
      drive(2, 1'b1, 16'hB001, 1'b0);
      drive(0, 1'b1, 16'hC001, 1'b1);
      tick();
      chk("t2_b1_data",   out_tdata,  16'hB001);
      chk("t2_busy",      mux_idle,   1'b0);
      cfg_sel = 3'd0;
      drive(2, 1'b1, 16'hB002, 1'b0);
      tick();
      chk("t2_b2_data",   out_tdata,  16'hB002);
      chk("t2_b2_pend",   sel_pend,   1'b1);
      chk("t2_b2_tready", in_tready,  4'b0100);
      drive(2, 1'b1, 16'hB003, 1'b0);
      tick();
      chk("t2_b3_data",   out_tdata,  16'hB003);
      chk("t2_b3_pend",   sel_pend,   1'b1);
      chk("t2_b3_tready", in_tready,  4'b0100);
      drive(2, 1'b1, 16'hB004, 1'b1);
      tick();
      chk("t2_b4_data",   out_tdata,  16'hB004);
      chk("t2_b4_last",   out_tlast,  1'b1);
      chk("t2_switch",    cur_sel,    3'd0);
      chk("t2_pend_off",  sel_pend,   1'b0);
      chk("t2_tready0",   in_tready,  4'b0001);
      chk("t2_cnt2",      pkt_cnt,    4'd2);
      drive(2, 1'b0, 16'h0000, 1'b0);
      tick();
      chk("t2_c1_data",   out_tdata,  16'hC001);
      chk("t2_c1_last",   out_tlast,  1'b1);
      chk("t2_cnt3",      pkt_cnt,    4'd3);
      drive(0, 1'b0, 16'h0000, 1'b0);
      tick();
      chk("t2_drained",   out_tvalid, 1'b0);

      // 3: backpressure, two beats absorbed then stall
      cfg_sel    = 3'd2;
      out_tready = 1'b0;
      tick();
      chk("t3_tready",    in_tready,  4'b0100);
      drive(2, 1'b1, 16'hD001, 1'b0);
      tick();
      chk("t3_d1_valid",  out_tvalid, 1'b1);
      chk("t3_d1_data",   out_tdata,  16'hD001);
      drive(2, 1'b1, 16'hD002, 1'b0);
      tick();
      chk("t3_full",      in_tready,  4'b0000);
      drive(2, 1'b1, 16'hD003, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      chk("t3_stall_rdy", in_tready,  4'b0000);
      chk("t3_hold_vld",  out_tvalid, 1'b1);
      chk("t3_hold_data", out_tdata,  16'hD001);
      chk("t3_hold_last", out_tlast,  1'b0);
      chk("t3_hold_cnt",  pkt_cnt,    4'd3);
      out_tready = 1'b1;
      tick();
      chk("t3_r1_data",   out_tdata,  16'hD002);
      chk("t3_r1_rdy",    in_tready,  4'b0100);
      tick();
      chk("t3_r2_data",   out_tdata,  16'hD003);
      chk("t3_r2_last",   out_tlast,  1'b1);
      chk("t3_r2_cnt",    pkt_cnt,    4'd4);
      drive(2, 1'b0, 16'h0000, 1'b0);
      tick();
      chk("t3_drained",   out_tvalid, 1'b0);

      // 4: select none, every input valid
      cfg_sel = 3'd4;
      tick();
      chk("t4_cur_sel",   cur_sel,    3'd4);
      for (int i = 0; i < NUM_IN; i++) drive(i, 1'b1, 16'hE000 + 16'(i), 1'b1);
      tick();
      tick();
      tick();
      chk("t4_tready",    in_tready,  4'b0000);
      chk("t4_no_out",    out_tvalid, 1'b0);
      chk("t4_cnt",       pkt_cnt,    4'd4);
      for (int i = 0; i < NUM_IN; i++) drive(i, 1'b0, 16'h0000, 1'b0);
      tick();

      // 5: counter saturation and clear priority
      cfg_sel = 3'd1;
      tick();
      chk("t5_tready",    in_tready,  4'b0010);
      drive(1, 1'b1, 16'h5555, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      chk("t5_cnt14",     pkt_cnt,    4'd14);
      tick();
      chk("t5_cnt15",     pkt_cnt,    4'd15);
      tick();
      tick();
      chk("t5_sat",       pkt_cnt,    4'd15);
      cnt_clr = 1'b1;
      tick();
      chk("t5_clr_prio",  pkt_cnt,    4'd0);
      cnt_clr = 1'b0;
      tick();
      chk("t5_after_clr", pkt_cnt,    4'd1);
      drive(1, 1'b0, 16'h0000, 1'b0);
      tick();
      tick();

      // 6: reset during a packet, then a clean packet
      cfg_sel = 3'd3;
      tick();
      drive(3, 1'b1, 16'hF001, 1'b0);
      tick();
      chk("t6_in_pkt",    mux_idle,   1'b0);
      drive(3, 1'b1, 16'hF002, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_vld",   out_tvalid, 1'b0);
      chk("t6_rst_data",  out_tdata,  16'h0000);
      chk("t6_rst_last",  out_tlast,  1'b0);
      chk("t6_rst_rdy",   in_tready,  4'b0000);
      chk("t6_rst_sel",   cur_sel,    3'b111);
      chk("t6_rst_pend",  sel_pend,   1'b0);
      chk("t6_rst_cnt",   pkt_cnt,    4'd0);
      chk("t6_rst_idle",  mux_idle,   1'b1);
      rst_n = 1'b1;
      drive(3, 1'b1, 16'hF003, 1'b1);
      tick();
      chk("t6_sel",       cur_sel,    3'd3);
      chk("t6_rdy",       in_tready,  4'b1000);
      chk("t6_no_out",    out_tvalid, 1'b0);
      tick();
      chk("t6_new_data",  out_tdata,  16'hF003);
      chk("t6_new_last",  out_tlast,  1'b1);
      chk("t6_new_cnt",   pkt_cnt,    4'd1);
      drive(3, 1'b0, 16'h0000, 1'b0);
      tick();
      chk("t6_drained",   out_tvalid, 1'b0);
      chk("t6_idle",      mux_idle,   1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
